div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Sequencer for the shared iterative integer divider used by the execute/memory stage for div.w/mod.w/div.wu/mod.wu.
- Accepts the stage's division request bundle {req, mod, unsigned, src1, src2}.
- Runs a radix-2 restoring shift-subtract loop under an FSM, applies sign fix-up, and holds the result with div_ok until the instruction leaves the stage.
- Flushes from branch/exception redirect abort in-flight work.

Parameters:
- ITER_PER_CYCLE, 1, quotient bits resolved per clock; legal values 1, 2, 4. CALC length = 32/ITER_PER_CYCLE cycles.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- div_req  input  1  valid division in stage; held high with stable operands while stage is stalled
- div_mod  input  1  1 = return remainder, 0 = return quotient
- div_unsigned  input  1  1 = unsigned operands
- div_src1  input  32  dividend
- div_src2  input  32  divisor
- div_adv  input  1  stage instruction advances this cycle (writeback ready and stage unblocked)
- div_cancel  input  1  flush of the instruction in stage
- div_result  output  32  quotient or remainder; valid when div_ok=1 and div_req=1
- div_ok  output  1  stage may proceed: ~div_req | (state==DONE)
- div_busy  output  1  state is CALC or FIX

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high. Reset forces IDLE, clears all datapath registers, and drives div_result=0 and div_busy=0. div_ok=1 while div_req=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If div_req & ~div_cancel: latch |src1| and |src2| (raw values if unsigned), latch sign_q = src1[31]^src2[31] and sign_r = src1[31] (both 0 if unsigned), latch the mod flag, clear the partial remainder and the iteration counter, then go to CALC.
- CALC:
  - Each cycle performs ITER_PER_CYCLE restoring steps on a 33-bit partial remainder: shift in the next dividend MSB, subtract the divisor, keep the result if non-negative, and set the quotient bit.
  - A 6-bit counter goes to FIX after 32/ITER_PER_CYCLE cycles.
- FIX:
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - Select the output by the mod flag, register it into div_result, then go to DONE.
- DONE:
  - div_ok=1 and div_result is held stable.
  - div_adv or div_cancel: go to IDLE. A new request is sampled in IDLE on the following cycle; no same-cycle restart.
- Latency: request sampled in IDLE at cycle 0 → div_ok high at cycle 32/ITER_PER_CYCLE + 2 (34 for ITER_PER_CYCLE=1).
- div_ok is combinational, so it is low in the same cycle div_req rises from IDLE; no bubble is allowed that could let the stage advance early.
- Division by zero: quotient 0xFFFFFFFF, remainder = src1, for both signed and unsigned. The loop naturally yields these values before fix-up; FIX must not negate the quotient when the divisor is zero.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. Absolute values use 33-bit arithmetic so no overflow trap is possible.
- Abort: div_cancel in any state, or div_req falling while in CALC/FIX, returns the FSM to IDLE next cycle. No result is produced and div_result keeps its previous value.
- Simultaneous cancel and start in IDLE: no start.
- div_adv in IDLE, CALC or FIX is ignored, because the stage cannot advance while div_ok=0.
- Reset mid-CALC: IDLE on the next edge; the counter and datapath registers are cleared.
- Operand changes while in CALC are ignored, since operands are latched at start.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the latched divisor is zero or |src1| < |src2|, skip CALC and go directly to FIX with quotient=0 (or 0xFFFFFFFF when the divisor is zero) and remainder=|src1|. div_ok then rises at cycle 2.
- Undefined: every request takes the full CALC length.

Test Plan:
- Unsigned quotient: ITER_PER_CYCLE=1, src1=100, src2=7, mod=0, unsigned=1, req held → div_ok low for cycles 0-33, high at cycle 34 with result 14; div_adv at cycle 34 → IDLE at cycle 35.
- Signed remainder: src1=0xFFFFFF9C (-100), src2=7, mod=1 → result 0xFFFFFFFE (-2). Same operands with mod=0 → 0xFFFFFFF2 (-14).
- Edge operands:
  - src2=0, signed, mod=0 → 0xFFFFFFFF.
  - src2=0, mod=1, src1=0x12345678 → 0x12345678.
  - src1=0x80000000, src2=0xFFFFFFFF, signed, mod=0 → 0x80000000; mod=1 → 0.
- Cancel mid-op: div_cancel pulsed at cycle 10 → IDLE at cycle 11, div_busy=0, div_result unchanged. A new request at cycle 12 completes at cycle 46 with the correct value.
- Stall in DONE: div_adv held low for 5 cycles in DONE → div_ok and div_result stable throughout. Back-to-back: adv then a new request the next cycle → second result 34 cycles later.
- ITER_PER_CYCLE=4: 0xFFFFFFFF / 3 unsigned → 0x55555555 with div_ok at cycle 10. With DIV_EARLY_OUT_EN, 5 / 9 → quotient 0 at cycle 2.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequencer for the shared iterative integer divider (div.w/mod.w/div.wu/mod.wu).
// Define DIV_EARLY_OUT_EN to skip the loop when the divisor is zero or |src1| < |src2|.
module div_seq_ctrl #(
    parameter int unsigned ITER_PER_CYCLE = 1  // legal values: 1, 2, 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_req_i,
    input  logic        div_mod_i,
    input  logic        div_unsigned_i,
    input  logic [31:0] div_src1_i,
    input  logic [31:0] div_src2_i,
    input  logic        div_adv_i,
    input  logic        div_cancel_i,
    output logic [31:0] div_result_o,
    output logic        div_ok_o,
    output logic        div_busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int         ITERS    = int'(ITER_PER_CYCLE);
    localparam logic [5:0] LAST_CNT = 6'(32 / ITER_PER_CYCLE - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] quo_q, quo_d;  // holds the dividend; quotient bits shift in from the right
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        mod_q, mod_d;
    logic [31:0] result_q, result_d;

    logic        sgn1, sgn2;
    logic [31:0] abs1, abs2;
    logic [31:0] step_quo, step_rem;
    logic [31:0] quo_fix, rem_fix;

    assign sgn1 = ~div_unsigned_i & div_src1_i[31];
    assign sgn2 = ~div_unsigned_i & div_src2_i[31];
    // 33-bit negate so that |0x80000000| comes out as 0x80000000 unsigned
    assign abs1 = sgn1 ? 32'(33'd0 - {1'b1, div_src1_i}) : div_src1_i;
    assign abs2 = sgn2 ? 32'(33'd0 - {1'b1, div_src2_i}) : div_src2_i;

    always_comb begin
        logic [32:0] shifted;
        logic [32:0] diff;
        shifted  = '0;
        diff     = '0;
        step_quo = quo_q;
        step_rem = rem_q;
        for (int i = 0; i < ITERS; i++) begin
            shifted  = {step_rem, step_quo[31]};
            diff     = shifted - {1'b0, dvs_q};
            step_quo = {step_quo[30:0], ~diff[32]};
            step_rem = diff[32] ? shifted[31:0] : diff[31:0];
        end
    end

    // A zero divisor leaves an all-ones quotient that must not be negated
    assign quo_fix = (neg_quo_q && (dvs_q != 32'd0)) ? 32'd0 - quo_q : quo_q;
    assign rem_fix = neg_rem_q ? 32'd0 - rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        mod_d     = mod_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (div_req_i && !div_cancel_i) begin
                    quo_d     = abs1;
                    dvs_d     = abs2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = sgn1 ^ sgn2;
                    neg_rem_d = sgn1;
                    mod_d     = div_mod_i;
                    state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
                    if ((abs2 == 32'd0) || (abs1 < abs2)) begin
                        quo_d   = (abs2 == 32'd0) ? '1 : '0;
                        rem_d   = abs1;
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                if (div_cancel_i || !div_req_i) begin
                    state_d = IDLE;
                end else begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (div_cancel_i || !div_req_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = mod_q ? rem_fix : quo_fix;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (div_adv_i || div_cancel_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mod_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            mod_q     <= mod_d;
            result_q  <= result_d;
        end
    end

    assign div_result_o = result_q;
    assign div_ok_o     = ~div_req_i | (state_q == DONE);
    assign div_busy_o   = (state_q == CALC) | (state_q == FIX);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table plus hand-written abort/reset sequences.
// Two instances: one resolving 1 quotient bit per cycle, one resolving 4.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req1, req4, dmod, duns, adv, cancel;
    logic [31:0] src1, src2;
    logic [31:0] res1, res4;
    logic        ok1, ok4, busy1, busy4;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp1 = '0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.ITER_PER_CYCLE(1)) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .div_req_i     (req1),
        .div_mod_i     (dmod),
        .div_unsigned_i(duns),
        .div_src1_i    (src1),
        .div_src2_i    (src2),
        .div_adv_i     (adv),
        .div_cancel_i  (cancel),
        .div_result_o  (res1),
        .div_ok_o      (ok1),
        .div_busy_o    (busy1)
    );

    div_seq_ctrl #(.ITER_PER_CYCLE(4)) u_dut4 (
        .clk           (clk),
        .reset         (reset),
        .div_req_i     (req4),
        .div_mod_i     (dmod),
        .div_unsigned_i(duns),
        .div_src1_i    (src1),
        .div_src2_i    (src2),
        .div_adv_i     (adv),
        .div_cancel_i  (cancel),
        .div_result_o  (res4),
        .div_ok_o      (ok4),
        .div_busy_o    (busy4)
    );

    typedef struct {
        bit          sel4;
        bit          m;
        bit          u;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          hold;
        bit          chain;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] x, input bit u);
        return (!u && x[31]) ? 32'd0 - x : x;
    endfunction

    function automatic int lat_of(input bit sel4, input logic [31:0] a, input logic [31:0] b,
                                  input bit u);
        int l;
        l = sel4 ? 10 : 34;
`ifdef DIV_EARLY_OUT_EN
        if ((b == 32'd0) || (mag(a, u) < mag(b, u))) l = 2;
`endif
        return l;
    endfunction

    function automatic logic [31:0] model(input bit m, input bit u, input logic [31:0] a,
                                          input logic [31:0] b);
        if (b == 32'd0) return m ? a : 32'hFFFF_FFFF;
        if (u) return m ? a % b : a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'd0 : 32'h8000_0000;
        return m ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    endfunction

    task automatic run_op(input bit sel4, input bit m, input bit u, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input int hold,
                          input bit start_now, input bit chain);
        int          n;
        logic [31:0] want;
        if (!start_now) begin
            @(posedge clk); #1;
        end
        dmod = m; duns = u; src1 = a; src2 = b; adv = 1'b0;
        if (sel4) req4 = 1'b1; else req1 = 1'b1;
        sb_q.push_back(e);
        #1;
        check("ok_low_at_start", {31'd0, sel4 ? ok4 : ok1}, 32'd0);
        n = 0;
        while (!(sel4 ? ok4 : ok1) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("latency", n, lat_of(sel4, a, b, u));
        want = '0;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            want = sb_q.pop_front();
            check("result", sel4 ? res4 : res1, want);
        end
        if (!sel4) last_exp1 = want;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #2;
            check("stall_ok", {31'd0, sel4 ? ok4 : ok1}, 32'd1);
            check("stall_result", sel4 ? res4 : res1, want);
        end
        adv = 1'b1;
        @(posedge clk); #1;
        check("adv_to_idle", {31'd0, sel4 ? ok4 : ok1}, 32'd0);
        adv = 1'b0;
        if (!chain) begin
            req1 = 1'b0;
            req4 = 1'b0;
        end
    endtask

    initial begin
        bit prev_chain;
        reset = 1'b1; req1 = 1'b0; req4 = 1'b0; dmod = 1'b0; duns = 1'b0;
        src1 = '0; src2 = '0; adv = 1'b0; cancel = 1'b0;

        vecs[0]  = '{0, 0, 1, 32'd100,        32'd7,        32'd14,        0, 0};
        vecs[1]  = '{0, 1, 0, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE, 0, 0};
        vecs[2]  = '{0, 0, 0, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 0, 0};
        vecs[3]  = '{0, 0, 0, 32'd5,          32'd0,        32'hFFFF_FFFF, 0, 0};
        vecs[4]  = '{0, 1, 0, 32'h1234_5678,  32'd0,        32'h1234_5678, 0, 0};
        vecs[5]  = '{0, 0, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0, 0};
        vecs[6]  = '{0, 1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        0, 0};
        vecs[7]  = '{0, 0, 1, 32'd1000,       32'd10,       32'd100,       5, 1};
        vecs[8]  = '{0, 1, 1, 32'd1000,       32'd7,        32'd6,         0, 0};
        vecs[9]  = '{1, 0, 1, 32'hFFFF_FFFF,  32'd3,        32'h5555_5555, 0, 0};
        vecs[10] = '{1, 0, 1, 32'd5,          32'd9,        32'd0,         0, 0};
        vecs[11] = '{0, 1, 0, 32'hFFFF_FF9C,  32'd0,        32'hFFFF_FF9C, 0, 0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_result1", res1, 32'd0);
        check("reset_busy1", {31'd0, busy1}, 32'd0);
        check("reset_ok1", {31'd0, ok1}, 32'd1);
        check("reset_result4", res4, 32'd0);
        check("reset_busy4", {31'd0, busy4}, 32'd0);

        prev_chain = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].sel4, vecs[i].m, vecs[i].u, vecs[i].a, vecs[i].b, vecs[i].e,
                   vecs[i].hold, prev_chain, vecs[i].chain);
            prev_chain = vecs[i].chain;
        end

        for (int k = 0; k < 6; k++) begin
            logic [31:0] a, b;
            bit m, u;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (k == 4) b = 32'd0;
            u = k[0];
            m = k[1];
            run_op(k == 5, m, u, a, b, model(m, u, a, b), 0, 0, 0);
        end

        // Cancel at cycle 10, restart at cycle 12
        @(posedge clk); #1;
        src1 = 32'd100; src2 = 32'd7; dmod = 1'b0; duns = 1'b1; req1 = 1'b1;
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1;
        #1 check("busy_before_cancel", {31'd0, busy1}, 32'd1);
        @(posedge clk); #1;
        cancel = 1'b0; req1 = 1'b0;
        #1;
        check("cancel_busy", {31'd0, busy1}, 32'd0);
        check("cancel_result_kept", res1, last_exp1);
        run_op(0, 0, 1, 32'd100, 32'd7, 32'd14, 0, 0, 0);

        // Cancel and start together in IDLE must not start
        @(posedge clk); #1;
        src1 = 32'd100; src2 = 32'd7; req1 = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        check("cancel_start_busy", {31'd0, busy1}, 32'd0);
        check("cancel_start_ok", {31'd0, ok1}, 32'd0);
        cancel = 1'b0; req1 = 1'b0;

        // Request dropping mid-CALC aborts
        @(posedge clk); #1;
        src1 = 32'd100; src2 = 32'd7; req1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 req1 = 1'b0;
        @(posedge clk); #2;
        check("req_drop_busy", {31'd0, busy1}, 32'd0);
        check("req_drop_result_kept", res1, last_exp1);

        // Reset mid-CALC clears everything
        @(posedge clk); #1;
        src1 = 32'd100; src2 = 32'd7; req1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1; req1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid_busy", {31'd0, busy1}, 32'd0);
        check("reset_mid_result", res1, 32'd0);
        run_op(0, 1, 0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0, 0, 0);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
